// File: rtl/cmp_frame_packer.sv
// cmp_frame_packer: packs the two comparator sample streams (S11 -> p0,
// S21 -> p1) into fixed frames of
//   {SYNC_BYTE, header, p0 field, p1 field}
// and queues them in a 2-entry show-ahead output FIFO. A frame that finds the
// FIFO full is dropped and counted in a saturating counter.
// Optional macro CMP_FRAME_PARITY_EN: header = {seq[6:0], even parity over
// the payload}; otherwise header = seq[7:0].
module cmp_frame_packer #(
    parameter int unsigned CH_BITS   = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned OVF_W     = 16
) (
    input  logic                     sample_clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     cmp_data_p0,
    input  logic                     cmp_data_p1,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [16+2*CH_BITS-1:0]  frame_data,
    output logic [OVF_W-1:0]         overflow_cnt,
    output logic [7:0]               seq_num
);

    localparam int unsigned FRAME_W = 16 + 2 * CH_BITS;
    localparam int unsigned IDX_W   = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CH_BITS-1:0] p0_sr_q, p0_sr_d;
    logic [CH_BITS-1:0] p1_sr_q, p1_sr_d;
    logic [7:0]         seq_q, seq_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic [FRAME_W-1:0] ent0_q, ent0_d;
    logic [FRAME_W-1:0] ent1_q, ent1_d;
    logic               vld0_q, vld0_d;
    logic               vld1_q, vld1_d;

    logic [CH_BITS-1:0] p0_field_c;
    logic [CH_BITS-1:0] p1_field_c;
    logic [7:0]         header_c;
    logic [FRAME_W-1:0] frame_c;
    logic               complete_c;
    logic               pop_c;

    // Assemble the frame completed by this edge's samples; first sample ends up as the MSB.
    always_comb begin
        p0_field_c = {p0_sr_q[CH_BITS-2:0], cmp_data_p0};
        p1_field_c = {p1_sr_q[CH_BITS-2:0], cmp_data_p1};
`ifdef CMP_FRAME_PARITY_EN
        header_c   = {seq_q[6:0], ^{p0_field_c, p1_field_c}};
`else
        header_c   = seq_q;
`endif
        frame_c    = {SYNC_BYTE, header_c, p0_field_c, p1_field_c};
        complete_c = capture_en && (idx_q == IDX_W'(CH_BITS - 1));
        pop_c      = vld0_q && frame_ready;
    end

    // Sample capture, bit index and sequence number.
    always_comb begin
        idx_d   = idx_q;
        p0_sr_d = p0_sr_q;
        p1_sr_d = p1_sr_q;
        seq_d   = seq_q;
        if (capture_en) begin
            p0_sr_d = p0_field_c;
            p1_sr_d = p1_field_c;
            if (complete_c) begin
                idx_d = '0;
                seq_d = seq_q + 8'd1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output FIFO: pop shifts the tail forward, then a completed frame fills the first free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        ovf_d  = ovf_q;
        if (pop_c) begin
            ent0_d = ent1_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end
        if (complete_c) begin
            if (!vld0_d) begin
                ent0_d = frame_c;
                vld0_d = 1'b1;
            end else if (!vld1_d) begin
                ent1_d = frame_c;
                vld1_d = 1'b1;
            end else if (ovf_q != {OVF_W{1'b1}}) begin
                ovf_d = ovf_q + OVF_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset drops any partial frame and queued frames.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            idx_q   <= '0;
            p0_sr_q <= '0;
            p1_sr_q <= '0;
            seq_q   <= '0;
            ovf_q   <= '0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            p0_sr_q <= p0_sr_d;
            p1_sr_q <= p1_sr_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
        end
    end

    assign frame_valid  = vld0_q;
    assign frame_data   = ent0_q;
    assign overflow_cnt = ovf_q;
    assign seq_num      = seq_q;

endmodule

// File: tb/tb_cmp_frame_packer.sv
// Bench for cmp_frame_packer: directed scenarios plus a randomized phase,
// all compared every cycle against a frame-level queue model.
module tb_cmp_frame_packer;

    localparam int unsigned CH = 32;
    localparam int unsigned FW = 16 + 2 * CH;

    logic          sample_clk;
    logic          reset;
    logic          capture_en;
    logic          cmp_data_p0;
    logic          cmp_data_p1;
    logic          frame_valid;
    logic          frame_ready;
    logic [FW-1:0] frame_data;
    logic [15:0]   overflow_cnt;
    logic [7:0]    seq_num;

    int checks;
    int failures;

    // Reference model state
    int            midx;
    int            mseq;
    int            movf;
    logic [CH-1:0] m0, m1;
    logic [FW-1:0] mq[$];

    cmp_frame_packer dut (
        .sample_clk   (sample_clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .cmp_data_p0  (cmp_data_p0),
        .cmp_data_p1  (cmp_data_p1),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .overflow_cnt (overflow_cnt),
        .seq_num      (seq_num)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sequence number as carried in the header, and what it should be for seq s.
    function automatic logic [7:0] hdr_seq(input logic [FW-1:0] f);
`ifdef CMP_FRAME_PARITY_EN
        return {1'b0, f[2*CH+7:2*CH+1]};
`else
        return f[2*CH+7:2*CH];
`endif
    endfunction

    function automatic logic [7:0] seq_field(input int s);
`ifdef CMP_FRAME_PARITY_EN
        return 8'(s % 128);
`else
        return 8'(s % 256);
`endif
    endfunction

    task automatic model_check();
        chk("frame_valid", FW'(frame_valid), FW'(mq.size() > 0));
        if (mq.size() > 0) chk("frame_data", frame_data, mq[0]);
        chk("overflow_cnt", FW'(overflow_cnt), FW'(movf));
        chk("seq_num", FW'(seq_num), FW'(mseq));
    endtask

    // One clock: drive at negedge, update model at the edge, compare at the next negedge.
    task automatic cyc(input logic cap, input logic a, input logic b, input logic rdy);
        logic [7:0]    hdr;
        logic          pop;
        capture_en  = cap;
        cmp_data_p0 = a;
        cmp_data_p1 = b;
        frame_ready = rdy;
        @(posedge sample_clk);
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            m0[CH-1-midx] = a;
            m1[CH-1-midx] = b;
            midx++;
            if (midx == CH) begin
`ifdef CMP_FRAME_PARITY_EN
                hdr = {7'(mseq % 128), ^{m0, m1}};
`else
                hdr = 8'(mseq);
`endif
                if (mq.size() < 2) mq.push_back({8'hA5, hdr, m0, m1});
                else if (movf < 65535) movf++;
                midx = 0;
                mseq = (mseq + 1) % 256;
            end
        end
        @(negedge sample_clk);
        model_check();
    endtask

    task automatic rst();
        reset = 1'b1;
        capture_en = 1'b0;
        frame_ready = 1'b0;
        @(posedge sample_clk);
        midx = 0;
        mseq = 0;
        movf = 0;
        mq.delete();
        @(negedge sample_clk);
        chk("rst_valid", FW'(frame_valid), '0);
        chk("rst_data", frame_data, '0);
        chk("rst_ovf", FW'(overflow_cnt), '0);
        chk("rst_seq", FW'(seq_num), '0);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m0 = '0;
        m1 = '0;
        reset = 1'b1;
        capture_en = 1'b0;
        cmp_data_p0 = 1'b0;
        cmp_data_p1 = 1'b0;
        frame_ready = 1'b0;
        @(negedge sample_clk);

        // 1: constant p0=1, p1=0
        rst();
        for (int i = 0; i < 31; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("s1_not_yet", FW'(frame_valid), '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("s1_valid", FW'(frame_valid), FW'(1));
        chk("s1_data", frame_data, 80'hA5_00_FFFFFFFF_00000000);
        chk("s1_seq", FW'(seq_num), FW'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 2: alternating p0, p1 = ~p0
        rst();
        for (int i = 0; i < 32; i++) cyc(1'b1, ~i[0], i[0], 1'b0);
        chk("s2_data", frame_data, {8'hA5, 8'h00, 32'hAAAAAAAA, 32'h55555555});

        // 3: back-pressure over 4 frames, then drain
        rst();
        for (int i = 0; i < 4 * 32; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s3_ovf", FW'(overflow_cnt), FW'(2));
        chk("s3_head0", FW'(hdr_seq(frame_data)), FW'(seq_field(0)));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s3_head1", FW'(hdr_seq(frame_data)), FW'(seq_field(1)));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s3_empty", FW'(frame_valid), '0);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s3_head4", FW'(hdr_seq(frame_data)), FW'(seq_field(4)));

        // 4: FIFO full, pop coincides with completion edge
        rst();
        for (int i = 0; i < 2 * 32 + 31; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b1);
        chk("s4_ovf", FW'(overflow_cnt), '0);
        chk("s4_head1", FW'(hdr_seq(frame_data)), FW'(seq_field(1)));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_occ2", FW'(frame_valid), FW'(1));
        chk("s4_head2", FW'(hdr_seq(frame_data)), FW'(seq_field(2)));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_drained", FW'(frame_valid), '0);

        // 5: capture gap of 10 cycles after 15 samples
        rst();
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s5_not_yet", FW'(frame_valid), '0);
        cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s5_valid", FW'(frame_valid), FW'(1));

        // 6: reset mid-frame with one frame queued
        rst();
        for (int i = 0; i < 32 + 20; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s6_queued", FW'(frame_valid), FW'(1));
        rst();
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        chk("s6_head0", FW'(hdr_seq(frame_data)), FW'(seq_field(0)));

        // Randomized traffic
        rst();
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
